output_decimator: RTL and testbench
===================================

OUTPUT_DECIMATOR -- requirements
Module: output_decimator

Interface
REQ-001 The block SHALL have parameter DATA_W, default 11, meaning the signed converter sample width.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 2, meaning output buffer entries (power of two, >=2).
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset, with ports as follows.
REQ-004 CLK_24M  input  1  system clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 clock_3M_in  input  1  converter sample clock, synchronous to CLK_24M, one 24 MHz cycle high per 8.
REQ-007 sample_in  input  DATA_W  two's-complement converter output, valid on the clock_3M_in rising-edge cycle.
REQ-008 enable  input  1  decimation enable.
REQ-009 DEC_SEL  input  2  decimation ratio select, N = 2^DEC_SEL (1, 2, 4, 8).
REQ-010 out_data  output  DATA_W+3  signed sum of N samples, head of FIFO.
REQ-011 out_valid  output  1  FIFO non-empty.
REQ-012 out_ready  input  1  consumer accepts out_data.
REQ-013 overflow  output  1  sticky flag: a result was dropped.
REQ-014 overflow_clr  input  1  clears overflow.

Function
REQ-015 Strobe SHALL be clock_3M_in high AND its value registered one cycle earlier low; a held-high input SHALL produce exactly one strobe.
REQ-016 Strobes SHALL be ignored while enable=0; accumulator and sample counter SHALL be held at 0 while enable=0.
REQ-017 On each enabled strobe, sample_in SHALL be sign-extended to DATA_W+3 and added to the accumulator; no saturation, width guarantees no wrap for N<=8.
REQ-018 The active ratio N SHALL be latched from DEC_SEL only when sample counter=0 at a strobe; DEC_SEL changes mid-block SHALL not affect the current block.
REQ-019 On the strobe at which sample counter = N-1, accumulator+sample_in SHALL be pushed to the FIFO at that edge, and accumulator and counter SHALL return to 0.
REQ-020 For N=1 every enabled strobe SHALL push sample_in sign-extended.
REQ-021 Latency: out_valid SHALL assert in the cycle after the final-strobe edge when the FIFO was empty.
REQ-022 Pop SHALL occur on any edge with out_valid=1 and out_ready=1; out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-023 Push to a full FIFO with simultaneous pop SHALL succeed (no drop, occupancy unchanged).
REQ-024 Push to a full FIFO without pop SHALL discard the new result, keep stored entries intact, and set overflow.
REQ-025 overflow_clr SHALL clear overflow on the next edge; a simultaneous drop event SHALL win (overflow stays 1).
REQ-026 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH; empty/full SHALL be distinguished by an extra pointer bit or an occupancy count.
REQ-027 Deasserting enable mid-block SHALL discard the partial sum; FIFO contents SHALL remain drainable.
REQ-028 out_data SHALL be registered or FIFO-read data with no combinational path from sample_in.

Reset
REQ-029 On reset assertion, accumulator, sample counter, latched N (to 1), strobe history, FIFO pointers, out_valid and overflow SHALL go to 0 immediately, without waiting for a clock.
REQ-030 out_data SHALL read 0 during reset.
REQ-031 Reset asserted mid-block or with FIFO full SHALL discard all partial and buffered results; after release, the first strobe SHALL start a new block at counter 0.
REQ-032 A clock_3M_in already high when reset releases SHALL not generate a strobe.

Verification
REQ-033 DEC_SEL=2, out_ready=1, samples 100, -50, 1023, -1024 -> one output 49, out_valid for one cycle, one cycle after the 4th strobe.
REQ-034 DEC_SEL=3, eight samples of -1024 -> out_data = -8192 (14-bit 0x2000), no wrap.
REQ-035 DEC_SEL=0, out_ready=0 for 3 strobes of 1, 2, 3 -> FIFO holds 1, 2; 3 dropped; overflow=1; then ready -> 1, 2 delivered in order.
REQ-036 FIFO full, out_ready=1 on the cycle of the next push -> no drop, overflow stays 0; overflow_clr coincident with a drop -> overflow stays 1.
REQ-037 DEC_SEL changed 2->0 after 2nd sample of a block -> that block still sums 4 samples; following outputs are per-sample.
REQ-038 reset pulse after 3 of 4 samples with one entry buffered -> out_valid=0 immediately; the next 4 strobes produce one correct sum.

Source files
------------

// File: rtl/output_decimator.sv
// Output decimator: sums N = 2^DEC_SEL converter samples per block.
// Each block result goes into a small FIFO with a ready/valid read side.
// A sticky overflow flag records any result dropped because the FIFO was full.
module output_decimator #(
    parameter int DATA_W     = 11,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                     CLK_24M,
    input  logic                     reset,
    input  logic                     clock_3M_in,
    input  logic signed [DATA_W-1:0] sample_in,
    input  logic                     enable,
    input  logic [1:0]               DEC_SEL,
    output logic [DATA_W+2:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     overflow,
    input  logic                     overflow_clr
);

    localparam int OUT_W = DATA_W + 3;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    // Strobe detection. 'armed' keeps a level that is already high at reset
    // release from being seen as a rising edge.
    logic clk3_q;
    logic armed;
    logic strobe;

    // Registers the previous clock_3M_in level and arms detection one cycle after reset.
    always_ff @(posedge CLK_24M or posedge reset) begin
        if (reset) begin
            clk3_q <= 1'b0;
            armed  <= 1'b0;
        end else begin
            clk3_q <= clock_3M_in;
            armed  <= 1'b1;
        end
    end

    assign strobe = clock_3M_in & ~clk3_q & armed & enable;

    // Accumulator and block control. At the start of a block (cnt==0) the
    // live DEC_SEL is used; mid-block the latched ratio governs.
    logic [OUT_W-1:0] acc;
    logic [2:0]       cnt;
    logic [1:0]       dec_q;
    logic [1:0]       cur_sel;
    logic [2:0]       last_idx;
    logic             last;
    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] sum;
    logic             push;

    assign cur_sel = (cnt == 3'd0) ? DEC_SEL : dec_q;

    // Maps the ratio select to the index of the final sample in a block.
    always_comb begin
        last_idx = 3'd0;
        case (cur_sel)
            2'd0: last_idx = 3'd0;
            2'd1: last_idx = 3'd1;
            2'd2: last_idx = 3'd3;
            default: last_idx = 3'd7;
        endcase
    end

    assign last = (cnt == last_idx);
    assign sext = {{3{sample_in[DATA_W-1]}}, sample_in};
    assign sum  = acc + sext;
    assign push = strobe & last;

    // Accumulates samples and clears on block completion or when disabled.
    always_ff @(posedge CLK_24M or posedge reset) begin
        if (reset) begin
            acc   <= '0;
            cnt   <= '0;
            dec_q <= 2'd0;
        end else if (!enable) begin
            acc <= '0;
            cnt <= '0;
        end else if (strobe) begin
            if (cnt == 3'd0) dec_q <= DEC_SEL;
            if (last) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= sum;
                cnt <= cnt + 3'd1;
            end
        end
    end

    // Output FIFO. Pointers carry an extra wrap bit to tell full from empty.
    logic [OUT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             empty;
    logic             full;
    logic             pop;
    logic             wr_en;
    logic             drop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop   = ~empty & out_ready;
    // A pop in the same cycle frees the slot the push needs.
    assign wr_en = push & (~full | pop);
    assign drop  = push & full & ~pop;

    // Advances read/write pointers on pop and accepted push.
    always_ff @(posedge CLK_24M or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Stores the completed block sum into the FIFO slot at the write pointer.
    always_ff @(posedge CLK_24M) begin
        if (wr_en) mem[wr_ptr[PTR_W-1:0]] <= sum;
    end

    // Sticky overflow; a drop in the same cycle overrides a clear.
    always_ff @(posedge CLK_24M or posedge reset) begin
        if (reset)             overflow <= 1'b0;
        else if (drop)         overflow <= 1'b1;
        else if (overflow_clr) overflow <= 1'b0;
    end

    assign out_valid = ~empty;
    // Gated so the output reads zero whenever the FIFO is empty, including in reset.
    assign out_data  = out_valid ? mem[rd_ptr[PTR_W-1:0]] : '0;

endmodule

// File: tb/tb_output_decimator.sv
// Randomised and directed bench for output_decimator against a queue-based
// reference model of the block-sum / FIFO behaviour.
module tb_output_decimator;

    localparam int DW    = 11;
    localparam int DEPTH = 2;

    typedef logic signed [DW-1:0] smp_t;

    logic              CLK_24M = 1'b0;
    logic              reset = 1'b1;
    logic              clock_3M_in = 1'b0;
    smp_t              sample_in = '0;
    logic              enable = 1'b1;
    logic [1:0]        DEC_SEL = 2'd0;
    logic [DW+2:0]     out_data;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic              overflow;
    logic              overflow_clr = 1'b0;

    output_decimator #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .CLK_24M(CLK_24M), .reset(reset), .clock_3M_in(clock_3M_in),
        .sample_in(sample_in), .enable(enable), .DEC_SEL(DEC_SEL),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .overflow(overflow), .overflow_clr(overflow_clr)
    );

    always #5 CLK_24M = ~CLK_24M;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    // Reference model: samples collected per block, FIFO as a bounded queue.
    int m_q[$];
    int m_blk[$];
    int m_n = 1;
    bit m_prev = 1'b1;
    bit m_ovf = 1'b0;

    function automatic void model_clear();
        m_q.delete();
        m_blk.delete();
        m_n    = 1;
        m_prev = 1'b1;   // a level already high at release is not an edge
        m_ovf  = 1'b0;
    endfunction

    function automatic void model_step();
        bit pop, push, drop, stb;
        int res;
        pop  = (m_q.size() > 0) && out_ready;
        stb  = clock_3M_in && !m_prev;
        m_prev = clock_3M_in;
        push = 1'b0;
        res  = 0;
        if (!enable) m_blk.delete();
        else if (stb) begin
            if (m_blk.size() == 0) m_n = 1 << DEC_SEL;
            m_blk.push_back(int'(sample_in));
            if (m_blk.size() == m_n) begin
                foreach (m_blk[k]) res += m_blk[k];
                push = 1'b1;
                m_blk.delete();
            end
        end
        drop = push && (m_q.size() == DEPTH) && !pop;
        if (pop) void'(m_q.pop_front());
        if (push && !drop) m_q.push_back(res);
        if (drop) m_ovf = 1'b1;
        else if (overflow_clr) m_ovf = 1'b0;
    endfunction

    task automatic check_outputs();
        chk("valid", int'(out_valid), int'(m_q.size() != 0));
        if (m_q.size() != 0) chk("data", int'($signed(out_data)), m_q[0]);
        else chk("data_idle", int'(out_data), 0);
        chk("overflow", int'(overflow), int'(m_ovf));
    endtask

    task automatic tick();
        @(posedge CLK_24M);
        if (!reset) model_step();
        @(negedge CLK_24M);
        check_outputs();
    endtask

    task automatic idle(input int n);
        clock_3M_in = 1'b0;
        repeat (n) begin
            sample_in = smp_t'($urandom);
            tick();
        end
    endtask

    // One strobe cycle carrying v; leaves the bench at the negedge after the push edge.
    task automatic strobe1(input int v);
        clock_3M_in = 1'b1;
        sample_in   = smp_t'(v);
        tick();
        clock_3M_in = 1'b0;
    endtask

    task automatic strobe_s(input int v);
        strobe1(v);
        idle(7);
    endtask

    task automatic do_reset(input int cyc);
        #2 reset = 1'b1;
        model_clear();
        #1;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_data", int'(out_data), 0);
        chk("rst_ovf", int'(overflow), 0);
        repeat (cyc) @(posedge CLK_24M);
        @(negedge CLK_24M);
        reset = 1'b0;
    endtask

    initial begin
        model_clear();
        #1;
        chk("init_valid", int'(out_valid), 0);
        chk("init_data", int'(out_data), 0);
        chk("init_ovf", int'(overflow), 0);

        // clock_3M_in held high across reset release: no strobe
        clock_3M_in = 1'b1;
        repeat (2) @(negedge CLK_24M);
        reset = 1'b0;
        repeat (4) tick();
        chk("held_high_nostrobe", int'(out_valid), 0);
        idle(3);

        // N=4 block sum
        DEC_SEL = 2'd2;
        out_ready = 1'b1;
        strobe_s(100); strobe_s(-50); strobe_s(1023);
        strobe1(-1024);
        chk("n4_valid", int'(out_valid), 1);
        chk("n4_sum", int'($signed(out_data)), 49);
        tick();
        chk("n4_one_cycle", int'(out_valid), 0);
        idle(6);

        // N=8 of most-negative samples, no wrap
        DEC_SEL = 2'd3;
        repeat (7) strobe_s(-1024);
        strobe1(-1024);
        chk("n8_sum", int'(out_data), 'h2000);
        idle(7);

        // N=1 with consumer stalled: third result dropped
        DEC_SEL = 2'd0;
        out_ready = 1'b0;
        strobe_s(1); strobe_s(2); strobe_s(3);
        chk("drop_ovf", int'(overflow), 1);
        chk("drop_head", int'($signed(out_data)), 1);
        out_ready = 1'b1;
        tick();
        chk("drain_second", int'($signed(out_data)), 2);
        tick();
        chk("drain_empty", int'(out_valid), 0);

        // push into full FIFO with simultaneous pop, then clear vs drop
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        chk("ovf_cleared", int'(overflow), 0);
        out_ready = 1'b0;
        strobe_s(5); strobe_s(6);
        out_ready = 1'b1;
        strobe1(7);
        out_ready = 1'b0;
        chk("full_pop_noovf", int'(overflow), 0);
        chk("full_pop_head", int'($signed(out_data)), 6);
        idle(7);
        overflow_clr = 1'b1;
        strobe1(8);
        overflow_clr = 1'b0;
        chk("clr_vs_drop", int'(overflow), 1);
        chk("drop_keeps_head", int'($signed(out_data)), 6);
        idle(3);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        out_ready = 1'b1;
        idle(4);

        // ratio change mid-block takes effect on the next block
        DEC_SEL = 2'd2;
        strobe_s(10); strobe_s(20);
        DEC_SEL = 2'd0;
        strobe_s(30);
        strobe1(40);
        chk("midblock_sum", int'($signed(out_data)), 100);
        idle(7);
        strobe1(-7);
        chk("per_sample_a", int'($signed(out_data)), -7);
        idle(7);
        strobe1(2);
        chk("per_sample_b", int'($signed(out_data)), 2);
        idle(7);

        // enable dropped mid-block discards partial sum
        DEC_SEL = 2'd2;
        strobe_s(50); strobe_s(60);
        enable = 1'b0;
        strobe_s(70);
        enable = 1'b1;
        strobe_s(1); strobe_s(2); strobe_s(3);
        strobe1(4);
        chk("enable_discard", int'($signed(out_data)), 10);
        idle(7);

        // reset mid-block with an entry buffered
        out_ready = 1'b0;
        DEC_SEL = 2'd0;
        strobe_s(9);
        DEC_SEL = 2'd2;
        strobe_s(1); strobe_s(2); strobe_s(3);
        do_reset(2);
        out_ready = 1'b1;
        idle(2);
        strobe_s(7); strobe_s(8); strobe_s(9);
        strobe1(10);
        chk("post_reset_sum", int'($signed(out_data)), 34);
        idle(7);

        // randomised traffic
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                do_reset(1);
                clock_3M_in = 1'b0;
            end
            enable       = ($urandom_range(0, 15) != 0);
            DEC_SEL      = 2'($urandom);
            out_ready    = ($urandom_range(0, 2) == 0);
            overflow_clr = ($urandom_range(0, 9) == 0);
            clock_3M_in  = ($urandom_range(0, 2) == 0);
            sample_in    = smp_t'($urandom);
            tick();
        end
        overflow_clr = 1'b0;
        out_ready = 1'b1;
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
